psram_arbiter: RTL

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arb_pkg.sv | 23 ++
 rtl/psram_req_slot.sv | 44 ++++
 rtl/psram_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/psram_arb_pkg.sv
// ----------------------------------------------------------------------------
// psram_arb_pkg
// Shared definitions for the PSRAM read/write arbiter.
//   - arb_state_t   : arbiter FSM state encoding (IDLE / ISSUE / WAIT)
//   - ADDR_W_DEF    : default PSRAM byte address width
//   - TIMEOUT_DEF   : default cycles to wait for mem_busy after a request
//   - WR_STARVE_DEF : default consecutive read grants allowed over a waiting write
//   - READ_FILL     : data returned for a read aborted by timeout
// ----------------------------------------------------------------------------
package psram_arb_pkg;

    localparam int         ADDR_W_DEF    = 22;
    localparam int         TIMEOUT_DEF   = 255;
    localparam int         WR_STARVE_DEF = 4;
    localparam logic [7:0] READ_FILL     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/psram_req_slot.sv
// ----------------------------------------------------------------------------
// psram_req_slot
// One-deep request address holding register. A load always overwrites the
// held address (latest request wins); a take empties the slot. Load has
// priority over take so a request arriving as the slot is consumed is kept.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_load, i_addr : capture i_addr and mark the slot full
//   i_take         : slot contents consumed by a grant
//   o_full, o_addr : slot occupancy and held address
// ----------------------------------------------------------------------------
module psram_req_slot
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_take,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_full <= 1'b0;
            r_addr <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_addr <= i_addr;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;

endmodule

// File: rtl/psram_arbiter.sv
// ----------------------------------------------------------------------------
// psram_arbiter
// Arbitrates cart reads and loader writes onto a single PSRAM byte controller.
// Reads normally win; a waiting write is forced through after WR_STARVE
// consecutive read grants. Each transaction is issued until mem_busy rises,
// then waited on until mem_busy falls. A request that never sees mem_busy
// is aborted after TIMEOUT cycles and flags timeout_err.
// Ports:
//   i_clk, i_reset                 : clock, asynchronous active-high reset
//   i_rd_req, i_rd_addr            : read request pulse and address
//   o_rd_data, o_rd_valid          : read result (held) and completion pulse
//   i_wr_req, i_wr_addr, i_wr_data : level write request, held until ack
//   o_wr_ack                       : write completion pulse
//   o_mem_rd_req, o_mem_wr_req     : requests to the PSRAM byte controller
//   o_mem_addr, o_mem_wdata        : registered address / write data
//   i_mem_rdata, i_mem_busy        : controller read data / busy
//   o_timeout_err, i_err_clr       : sticky timeout flag and its clear
// ----------------------------------------------------------------------------
module psram_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int WR_STARVE = WR_STARVE_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    output logic              o_wr_ack,
    output logic              o_mem_rd_req,
    output logic              o_mem_wr_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata,
    input  logic              i_mem_busy,
    output logic              o_timeout_err,
    input  logic              i_err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int SV_W  = $clog2(WR_STARVE + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_is_wr;
    logic [CNT_W-1:0]  r_cnt;
    logic [SV_W-1:0]   r_starve;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        r_rd_data;
    logic              r_rd_valid;
    logic              r_wr_ack;
    logic              r_timeout_err;

    logic              w_slot_full;
    logic [ADDR_W-1:0] w_slot_addr;
    logic              w_wr_pend;
    logic              w_rd_pend;
    logic [ADDR_W-1:0] w_rd_addr_sel;
    logic              w_starved;
    logic              w_grant_rd;
    logic              w_grant_wr;
    logic              w_timeout;
    logic              w_done;
    logic              w_mem_rd_req;
    logic              w_mem_wr_req;

    // The loader still holds wr_req during the cycle wr_ack is high; masking
    // it there prevents the finished write from being granted a second time.
    assign w_wr_pend = i_wr_req && !r_wr_ack;

    // A fresh rd_req bypasses the slot so an idle bus issues it next cycle;
    // it also supersedes any unissued address already held in the slot.
    assign w_rd_pend     = i_rd_req || w_slot_full;
    assign w_rd_addr_sel = i_rd_req ? i_rd_addr : w_slot_addr;
    assign w_starved     = (r_starve == SV_W'(WR_STARVE));

    assign w_grant_rd = (r_state == ST_IDLE) && w_rd_pend && !(w_wr_pend && w_starved);
    assign w_grant_wr = (r_state == ST_IDLE) && w_wr_pend && !w_grant_rd;

    assign w_timeout = (r_state == ST_ISSUE) && !i_mem_busy && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_done    = (r_state == ST_WAIT) && !i_mem_busy;

    psram_req_slot #(
        .ADDR_W (ADDR_W)
    ) u_rd_slot (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (i_rd_req && !w_grant_rd),
        .i_addr  (i_rd_addr),
        .i_take  (w_grant_rd),
        .o_full  (w_slot_full),
        .o_addr  (w_slot_addr)
    );

    always_comb begin
        w_state_next = r_state;
        w_mem_rd_req = 1'b0;
        w_mem_wr_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_rd || w_grant_wr) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_mem_rd_req = !r_is_wr;
                w_mem_wr_req = r_is_wr;
                if (i_mem_busy) begin
                    w_state_next = ST_WAIT;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_mem_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_is_wr       <= 1'b0;
            r_cnt         <= '0;
            r_starve      <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_rd_data     <= READ_FILL;
            r_rd_valid    <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_ack   <= 1'b0;

            if (w_grant_rd || w_grant_wr) begin
                r_is_wr    <= w_grant_wr;
                r_cnt      <= '0;
                r_mem_addr <= w_grant_wr ? i_wr_addr : w_rd_addr_sel;
                if (w_grant_wr) begin
                    r_mem_wdata <= i_wr_data;
                end
            end else if ((r_state == ST_ISSUE) && !i_mem_busy && !w_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_grant_wr || !i_wr_req) begin
                r_starve <= '0;
            end else if (w_grant_rd && w_wr_pend && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end

            // An aborted read still completes (with fill data) so the cart
            // never stalls; an aborted write is simply re-granted later.
            if (w_timeout && !r_is_wr) begin
                r_rd_data  <= READ_FILL;
                r_rd_valid <= 1'b1;
            end

            if (w_done) begin
                if (r_is_wr) begin
                    r_wr_ack <= 1'b1;
                end else begin
                    r_rd_data  <= i_mem_rdata;
                    r_rd_valid <= 1'b1;
                end
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_wr_ack      = r_wr_ack;
    assign o_mem_rd_req  = w_mem_rd_req;
    assign o_mem_wr_req  = w_mem_wr_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_timeout_err = r_timeout_err;

endmodule
